// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline blocks: default datapath/index widths
// and the hard-wired zero register index.
package mips_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [DEF_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage : mips_pkg

// File: rtl/wb_mux.sv
// Two-input writeback result select (memory load data vs ALU result), kept
// separate so the forwarding unit can reuse the identical selection.
module wb_mux #(
  parameter int DATA_W = 32
) (
  input  logic              sel_i,
  input  logic [DATA_W-1:0] a0_i,
  input  logic [DATA_W-1:0] a1_i,
  output logic [DATA_W-1:0] y_o
);

  assign y_o = sel_i ? a1_i : a0_i;

endmodule : wb_mux

// File: rtl/wb_regfile.sv
// MIPS writeback-stage register file: result select, 31 stored registers,
// two combinational read ports and a committed-write counter.
// Optional same-cycle write-through bypass is enabled by defining WB_BYPASS_EN.
module wb_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              regWriteW,
  input  logic              MemtoRegW,
  input  logic [DATA_W-1:0] readDataW,
  input  logic [DATA_W-1:0] AluOutW,
  input  logic [ADDR_W-1:0] WriteRegW,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] ResultW,
  output logic [31:0]       wrCount
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [1:NREGS-1];
  logic [31:0]       wr_count_q;
  logic [31:0]       wr_count_d;
  logic              commit;

  wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
    .sel_i (MemtoRegW),
    .a0_i  (AluOutW),
    .a1_i  (readDataW),
    .y_o   (ResultW)
  );

  assign commit = regWriteW && (WriteRegW != ADDR_W'(REG_ZERO));

  // Index 0 has no storage; each remaining entry owns its own enable.
  for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
    always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
        regs_q[gi] <= '0;
      end else if (commit && (WriteRegW == ADDR_W'(gi))) begin
        regs_q[gi] <= ResultW;
      end
    end
  end

  assign wr_count_d = commit ? wr_count_q + 32'd1 : wr_count_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  assign wrCount = wr_count_q;

  // A zero index matches no stored entry, so it falls through to the 0 default.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (ra1 == ADDR_W'(i)) rd1 = regs_q[i];
      if (ra2 == ADDR_W'(i)) rd2 = regs_q[i];
    end
`ifdef WB_BYPASS_EN
    if (commit && (ra1 == WriteRegW)) rd1 = ResultW;
    if (commit && (ra2 == WriteRegW)) rd2 = ResultW;
`endif
    if (clr) begin
      rd1 = '0;
      rd2 = '0;
    end
  end

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; expectations follow the
// WB_BYPASS_EN setting of the build.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        clr;
  logic        regWriteW;
  logic        MemtoRegW;
  logic [31:0] readDataW;
  logic [31:0] AluOutW;
  logic [4:0]  WriteRegW;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] ResultW;
  logic [31:0] wrCount;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt = 32'd0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk       (clk),
    .clr       (clr),
    .regWriteW (regWriteW),
    .MemtoRegW (MemtoRegW),
    .readDataW (readDataW),
    .AluOutW   (AluOutW),
    .WriteRegW (WriteRegW),
    .ra1       (ra1),
    .ra2       (ra2),
    .rd1       (rd1),
    .rd2       (rd2),
    .ResultW   (ResultW),
    .wrCount   (wrCount)
  );

  task automatic drive(input logic we, input logic m2r, input logic [31:0] rdata,
                       input logic [31:0] alu, input logic [4:0] wreg);
    regWriteW = we;
    MemtoRegW = m2r;
    readDataW = rdata;
    AluOutW   = alu;
    WriteRegW = wreg;
  endtask

  // Drive a write at the falling edge, let the next rising edge commit it.
  task automatic commit_cycle(input logic we, input logic m2r, input logic [31:0] rdata,
                              input logic [31:0] alu, input logic [4:0] wreg);
    @(negedge clk);
    drive(we, m2r, rdata, alu, wreg);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic test_reset;
    clr = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    ra1 = 5'd0; ra2 = 5'd0;
    #2;
    checks++;
    if (wrCount !== 32'd0) begin
      errors++; $display("FAIL reset_count: got %h want %h", wrCount, 32'd0);
    end
    // Release reset mid-cycle with a write pending; it commits at the first edge.
    @(negedge clk);
    clr = 1'b0;
    drive(1'b1, 1'b0, 32'd0, 32'h0000_0066, 5'd6);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    exp_cnt = 32'd1;
    ra1 = 5'd6;
    #1;
    checks++;
    if (rd1 !== 32'h0000_0066 || wrCount !== exp_cnt) begin
      errors++; $display("FAIL reset_first_commit: rd1 %h cnt %h want 00000066 %h", rd1, wrCount, exp_cnt);
    end
    commit_cycle(1'b1, 1'b0, 32'd0, 32'h0000_00AA, 5'd3);
    commit_cycle(1'b1, 1'b0, 32'd0, 32'h0000_0BBB, 5'd17);
    // Assert reset away from any edge: state clears without a clock.
    @(negedge clk);
    #2;
    clr = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #1;
      checks++;
      if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
        errors++; $display("FAIL reset_read_%0d: rd1 %h rd2 %h want 0 0", i, rd1, rd2);
      end
    end
    checks++;
    if (wrCount !== 32'd0) begin
      errors++; $display("FAIL reset_async_count: got %h want 0", wrCount);
    end
    // A write held through reset, even with bypass, must stay invisible.
    drive(1'b1, 1'b0, 32'd0, 32'h0000_0077, 5'd3);
    ra1 = 5'd3;
    #1;
    checks++;
    if (rd1 !== 32'd0) begin
      errors++; $display("FAIL reset_no_bypass: got %h want 0", rd1);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    clr = 1'b0;
    #1;
    exp_cnt = 32'd0;
    checks++;
    if (rd1 !== 32'd0 || wrCount !== exp_cnt) begin
      errors++; $display("FAIL reset_suppress: rd1 %h cnt %h want 0 0", rd1, wrCount);
    end
  endtask

  task automatic test_alu_commit;
    @(negedge clk);
    drive(1'b1, 1'b0, 32'hCAFE_0000, 32'h0000_1234, 5'd8);
    #1;
    checks++;
    if (ResultW !== 32'h0000_1234) begin
      errors++; $display("FAIL alu_result: got %h want 00001234", ResultW);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    exp_cnt = exp_cnt + 1;
    ra1 = 5'd8;
    #1;
    checks++;
    if (rd1 !== 32'h0000_1234 || wrCount !== exp_cnt) begin
      errors++; $display("FAIL alu_commit: rd1 %h cnt %h want 00001234 %h", rd1, wrCount, exp_cnt);
    end
  endtask

  task automatic test_load_commit;
    @(negedge clk);
    drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0005, 5'd31);
    #1;
    checks++;
    if (ResultW !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL load_result: got %h want deadbeef", ResultW);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    exp_cnt = exp_cnt + 1;
    ra2 = 5'd31;
    #1;
    checks++;
    if (rd2 !== 32'hDEAD_BEEF || wrCount !== exp_cnt) begin
      errors++; $display("FAIL load_commit: rd2 %h cnt %h want deadbeef %h", rd2, wrCount, exp_cnt);
    end
  endtask

  task automatic test_zero_reg;
    ra1 = 5'd0; ra2 = 5'd0;
    @(negedge clk);
    drive(1'b1, 1'b0, 32'd0, 32'hFFFF_FFFF, 5'd0);
    #1;
    checks++;
    if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
      errors++; $display("FAIL zero_same_cycle: rd1 %h rd2 %h want 0 0", rd1, rd2);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    #1;
    checks++;
    if (rd1 !== 32'd0 || rd2 !== 32'd0 || wrCount !== exp_cnt) begin
      errors++; $display("FAIL zero_reg: rd1 %h rd2 %h cnt %h want 0 0 %h", rd1, rd2, wrCount, exp_cnt);
    end
  endtask

  task automatic test_same_cycle;
    logic [31:0] exp_pre;
    commit_cycle(1'b1, 1'b0, 32'd0, 32'h0000_0001, 5'd9);
    exp_cnt = exp_cnt + 1;
    ra1 = 5'd9; ra2 = 5'd9;
`ifdef WB_BYPASS_EN
    exp_pre = 32'h0000_0002;
`else
    exp_pre = 32'h0000_0001;
`endif
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h0000_0002, 32'h0000_0003, 5'd9);
    #1;
    checks++;
    if (rd1 !== exp_pre || rd2 !== exp_pre) begin
      errors++; $display("FAIL same_cycle_pre: rd1 %h rd2 %h want %h", rd1, rd2, exp_pre);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    exp_cnt = exp_cnt + 1;
    #1;
    checks++;
    if (rd1 !== 32'h0000_0002 || rd2 !== 32'h0000_0002 || wrCount !== exp_cnt) begin
      errors++; $display("FAIL same_cycle_post: rd1 %h rd2 %h cnt %h want 00000002 %h", rd1, rd2, wrCount, exp_cnt);
    end
  endtask

  task automatic test_disabled_write;
    commit_cycle(1'b1, 1'b0, 32'd0, 32'h0000_0044, 5'd4);
    exp_cnt = exp_cnt + 1;
    ra1 = 5'd4;
    @(negedge clk);
    drive(1'b0, 1'b0, 32'd0, 32'h0000_0007, 5'd4);
    #1;
    checks++;
    if (rd1 !== 32'h0000_0044 || ResultW !== 32'h0000_0007) begin
      errors++; $display("FAIL disabled_pre: rd1 %h res %h want 00000044 00000007", rd1, ResultW);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    #1;
    checks++;
    if (rd1 !== 32'h0000_0044 || wrCount !== exp_cnt) begin
      errors++; $display("FAIL disabled_write: rd1 %h cnt %h want 00000044 %h", rd1, wrCount, exp_cnt);
    end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    force dut.wr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.wr_count_q;
    #1;
    checks++;
    if (wrCount !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL wrap_preset: got %h want ffffffff", wrCount);
    end
    commit_cycle(1'b1, 1'b0, 32'd0, 32'h0000_0202, 5'd2);
    exp_cnt = 32'd0;
    ra1 = 5'd2;
    #1;
    checks++;
    if (wrCount !== exp_cnt || rd1 !== 32'h0000_0202) begin
      errors++; $display("FAIL wrap: cnt %h rd1 %h want %h 00000202", wrCount, rd1, exp_cnt);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals [3];
    vals[0] = 32'h1111_0000;
    vals[1] = 32'h2222_0000;
    vals[2] = 32'h3333_0000;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'(i % 2), vals[i], ~vals[i], 5'(10 + i));
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    exp_cnt = exp_cnt + 3;
    // Even slots selected AluOutW (inverted value), odd slot selected readDataW.
    ra1 = 5'd10; ra2 = 5'd11;
    #1;
    checks++;
    if (rd1 !== 32'hEEEE_FFFF || rd2 !== 32'h2222_0000) begin
      errors++; $display("FAIL b2b_10_11: rd1 %h rd2 %h want eeeeffff 22220000", rd1, rd2);
    end
    ra1 = 5'd12; ra2 = 5'd8;
    #1;
    checks++;
    if (rd1 !== 32'hCCCC_FFFF || rd2 !== 32'h0000_1234 || wrCount !== exp_cnt) begin
      errors++; $display("FAIL b2b_12_8: rd1 %h rd2 %h cnt %h want ccccffff 00001234 %h", rd1, rd2, wrCount, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_alu_commit();
    test_load_commit();
    test_zero_reg();
    test_same_cycle();
    test_disabled_write();
    test_wrap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish in 100000 time units");
    $fatal(1, "timeout");
  end

endmodule : tb_wb_regfile
